// File: rtl/bypass_clk_if.sv
// bypass_clk_if: push-button, overflow and step-pulse signals of bypass_clk.
// Master drives PUSH/OVERFLOW; slave (the generator) drives SIG.
interface bypass_clk_if;
  logic PUSH;
  logic OVERFLOW;
  logic SIG;

  modport master (
    output PUSH,
    output OVERFLOW,
    input  SIG
  );

  modport slave (
    input  PUSH,
    input  OVERFLOW,
    output SIG
  );
endinterface

// File: rtl/bypass_clk.sv
// bypass_clk: push button -> one-cycle step pulse, sticky halt on overflow.
// BYPASS_CLK_DEBOUNCE_EN enables the DEBOUNCE_CYCLES debouncer.
module bypass_clk #(
  parameter int DEBOUNCE_CYCLES = 1
) (
  input  logic         CLK,
  input  logic         RST,
  bypass_clk_if.slave  bus
);

  if (DEBOUNCE_CYCLES < 1 || DEBOUNCE_CYCLES > 255) begin : g_param_chk
    $error("DEBOUNCE_CYCLES out of range 1..255");
  end

  logic r_s1;
  logic r_s2;
  logic r_db;
  logic r_halt;
  logic r_sig;
  logic w_rise;
  logic w_block;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_s1 <= 1'b0;
      r_s2 <= 1'b0;
    end else begin
      r_s1 <= bus.PUSH;
      r_s2 <= r_s1;
    end
  end

`ifdef BYPASS_CLK_DEBOUNCE_EN
  localparam logic [7:0] LP_LAST = 8'(DEBOUNCE_CYCLES - 1);

  logic [7:0] r_cnt;

  // db rises on the same edge the press is accepted
  assign w_rise = r_s2 & ~r_db & (r_cnt == LP_LAST);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_db  <= 1'b0;
      r_cnt <= 8'd0;
    end else if (r_s2 == r_db) begin
      r_cnt <= 8'd0;
    end else if (r_cnt == LP_LAST) begin
      r_db  <= r_s2;
      r_cnt <= 8'd0;
    end else begin
      r_cnt <= r_cnt + 8'd1;
    end
  end
`else
  assign w_rise = r_s2 & ~r_db;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_db <= 1'b0;
    end else begin
      r_db <= r_s2;
    end
  end
`endif

  // overflow on this edge already blocks the pulse
  assign w_block = bus.OVERFLOW | r_halt;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_halt <= 1'b0;
      r_sig  <= 1'b0;
    end else begin
      r_halt <= r_halt | bus.OVERFLOW;
      r_sig  <= w_rise & ~w_block;
    end
  end

  assign bus.SIG = r_sig;

endmodule

// File: tb/tb_bypass_clk.sv
// tb_bypass_clk: scoreboard bench for bypass_clk.
// dut0 uses DEBOUNCE_CYCLES=1, dut1 uses DEBOUNCE_CYCLES=4.
module tb_bypass_clk;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  int   q0[$];
  int   q1[$];

  bypass_clk_if if0();
  bypass_clk_if if1();

  bypass_clk #(.DEBOUNCE_CYCLES(1)) u_dut0 (
    .CLK (clk),
    .RST (rst),
    .bus (if0)
  );

  bypass_clk #(.DEBOUNCE_CYCLES(4)) u_dut1 (
    .CLK (clk),
    .RST (rst),
    .bus (if1)
  );

  always #50 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (if0.SIG === 1'b1) begin
      checks++;
      if (q0.size() == 0) begin
        errors++;
        $display("FAIL dut0_pulse got pulse at cycle %0d, required none", cyc);
      end else begin
        int e;
        e = q0.pop_front();
        if (e != cyc) begin
          errors++;
          $display("FAIL dut0_pulse got cycle %0d, required cycle %0d", cyc, e);
        end
      end
    end
  end

  always @(negedge clk) begin
    if (if1.SIG === 1'b1) begin
      checks++;
      if (q1.size() == 0) begin
        errors++;
        $display("FAIL dut1_pulse got pulse at cycle %0d, required none", cyc);
      end else begin
        int e;
        e = q1.pop_front();
        if (e != cyc) begin
          errors++;
          $display("FAIL dut1_pulse got cycle %0d, required cycle %0d", cyc, e);
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk(input string name, input logic act, input logic req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s got %b, required %b (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic press0(input int width, input int gap);
    if0.PUSH = 1'b1;
    tick(width);
    if0.PUSH = 1'b0;
    tick(gap);
  endtask

  initial begin
    int c;
    if0.PUSH = 1'b1;
    if0.OVERFLOW = 1'b0;
    if1.PUSH = 1'b1;
    if1.OVERFLOW = 1'b0;

    // reset held with button pressed
    repeat (3) begin
      tick(1);
      chk("rst_sig0", if0.SIG, 1'b0);
      chk("rst_sig1", if1.SIG, 1'b0);
    end
    c = cyc;
    rst = 1'b0;
    q0.push_back(c + 3);
`ifdef BYPASS_CLK_DEBOUNCE_EN
    q1.push_back(c + 6);
`else
    q1.push_back(c + 3);
`endif
    tick(6);
    if0.PUSH = 1'b0;
    if1.PUSH = 1'b0;
    tick(12);

    // single 2-cycle press
    q0.push_back(cyc + 3);
    press0(2, 5);

    // two presses: 2 high, 1 low, 1 high
    c = cyc;
    q0.push_back(c + 3);
    q0.push_back(c + 6);
    if0.PUSH = 1'b1;
    tick(2);
    if0.PUSH = 1'b0;
    tick(1);
    if0.PUSH = 1'b1;
    tick(1);
    if0.PUSH = 1'b0;
    tick(5);

    // one-cycle overflow, then two presses while halted
    if0.OVERFLOW = 1'b1;
    tick(1);
    if0.OVERFLOW = 1'b0;
    for (int p = 0; p < 2; p++) begin
      if0.PUSH = 1'b1;
      for (int i = 0; i < 2; i++) begin
        tick(1);
        chk("halt_sig0", if0.SIG, 1'b0);
      end
      if0.PUSH = 1'b0;
      for (int i = 0; i < 3; i++) begin
        tick(1);
        chk("halt_sig0", if0.SIG, 1'b0);
      end
    end

    // reset clears halt
    rst = 1'b1;
    tick(1);
    chk("rst2_sig0", if0.SIG, 1'b0);
    rst = 1'b0;
    tick(2);
    q0.push_back(cyc + 3);
    press0(2, 5);

    // overflow first seen on the edge db rises
    if0.PUSH = 1'b1;
    tick(2);
    if0.PUSH = 1'b0;
    if0.OVERFLOW = 1'b1;
    tick(1);
    if0.OVERFLOW = 1'b0;
    tick(5);

    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    tick(2);
    q0.push_back(cyc + 3);
    press0(2, 5);

    // dut1: 2-cycle glitch
    c = cyc;
`ifndef BYPASS_CLK_DEBOUNCE_EN
    q1.push_back(c + 3);
`endif
    if1.PUSH = 1'b1;
    tick(2);
    if1.PUSH = 1'b0;
    tick(10);

    // dut1: 6-cycle press
    c = cyc;
`ifdef BYPASS_CLK_DEBOUNCE_EN
    q1.push_back(c + 6);
`else
    q1.push_back(c + 3);
`endif
    if1.PUSH = 1'b1;
    tick(6);
    if1.PUSH = 1'b0;
    tick(12);

    checks++;
    if (q0.size() != 0) begin
      errors++;
      $display("FAIL dut0_missing got %0d pulses outstanding, required 0", q0.size());
    end
    checks++;
    if (q1.size() != 0) begin
      errors++;
      $display("FAIL dut1_missing got %0d pulses outstanding, required 0", q1.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
